// File: rtl/decode_stage.sv
// Decode stage: buffers IF output, decodes head, forwards operands, issues into ID/EX register.
// Latency: 1 cycle from valid buffer head to id_valid_o; push-to-head adds one buffer cycle.
// Backpressure: if_ready_o = buffer not full; head holds on load-use hazard or !ex_ready_i.
// Optional feature macro: DECODE_ILLEGAL_CHK_EN (flags illegal/unlisted encodings on id_ill_o).
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int FWD_SRCS   = 3,
    parameter int IBUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    output logic                     if_ready_o,
    input  logic [31:0]              if_pc_i,
    input  logic [31:0]              if_instr_i,
    output logic [4:0]               rs1_idx_o,
    output logic [4:0]               rs2_idx_o,
    input  logic [XLEN-1:0]          rs1_rdata_i,
    input  logic [XLEN-1:0]          rs2_rdata_i,
    input  logic [FWD_SRCS-1:0]      fwd_en_i,
    input  logic [5*FWD_SRCS-1:0]    fwd_idx_i,
    input  logic [XLEN*FWD_SRCS-1:0] fwd_data_i,
    input  logic                     ex_ld_i,
    input  logic [4:0]               ex_rd_idx_i,
    input  logic                     ex_ready_i,
    output logic                     id_valid_o,
    output logic [31:0]              id_pc_o,
    output logic [31:0]              id_instr_o,
    output logic [XLEN-1:0]          id_rs1_o,
    output logic [XLEN-1:0]          id_rs2_o,
    output logic [XLEN-1:0]          id_imm_o,
    output logic [4:0]               id_rd_idx_o,
    output logic                     id_rd_en_o,
    output logic                     id_ill_o,
    output logic [15:0]              stall_cnt_o
);
    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CW = $clog2(IBUF_DEPTH + 1);

    logic [31:0]   pc_buf_q    [IBUF_DEPTH];
    logic [31:0]   instr_buf_q [IBUF_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          head_vld, push, fire, hazard, stall_ev;
    logic [31:0]   head_instr, head_pc;
    logic          rs1_en, rs2_en, rd_en, known;
    logic          ill;
    logic [31:0]   imm32;
    logic [XLEN-1:0] imm_ext, rs1_fwd, rs2_fwd;
    logic          hit1, hit2;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(IBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_vld   = (count_q != '0);
    assign head_instr = instr_buf_q[rd_ptr_q];
    assign head_pc    = pc_buf_q[rd_ptr_q];
    assign if_ready_o = (count_q != CW'(IBUF_DEPTH));
    assign push       = if_valid_i & if_ready_o & ~flush_i;
    assign rs1_idx_o  = head_instr[19:15];
    assign rs2_idx_o  = head_instr[24:20];

    // Field decode of the head entry: register enables and 32-bit immediate.
    always_comb begin
        rs1_en = 1'b0;
        rs2_en = 1'b0;
        rd_en  = 1'b0;
        known  = 1'b1;
        imm32  = '0;
        case (head_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                rs1_en = 1'b1; rd_en = 1'b1;
                imm32  = {{20{head_instr[31]}}, head_instr[31:20]};
            end
            7'b0110011: begin
                rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
            end
            7'b1100011: begin
                rs1_en = 1'b1; rs2_en = 1'b1;
                imm32  = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                          head_instr[30:25], head_instr[11:8], 1'b0};
            end
            7'b0100011: begin
                rs1_en = 1'b1; rs2_en = 1'b1;
                imm32  = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
            end
            7'b1101111: begin
                rd_en  = 1'b1;
                imm32  = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                          head_instr[20], head_instr[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                rd_en  = 1'b1;
                imm32  = {head_instr[31:12], 12'b0};
            end
            7'b1110011: begin
                rd_en  = 1'b1;
                rs1_en = ~head_instr[14];
            end
            default: known = 1'b0;
        endcase
    end

    assign imm_ext = XLEN'($signed(imm32));

`ifdef DECODE_ILLEGAL_CHK_EN
    // Every listed opcode ends in 2'b11, so "unlisted" also covers compressed-style encodings.
    assign ill = ~known;
`else
    assign ill = 1'b0;
`endif

    // Operand forwarding: lowest matching channel wins, x0 reads zero, disabled operands pass rdata.
    always_comb begin
        rs1_fwd = rs1_rdata_i;
        rs2_fwd = rs2_rdata_i;
        hit1    = 1'b0;
        hit2    = 1'b0;
        for (int k = 0; k < FWD_SRCS; k++) begin
            if (!hit1 && fwd_en_i[k] && fwd_idx_i[5*k +: 5] == rs1_idx_o && rs1_idx_o != 5'd0) begin
                rs1_fwd = fwd_data_i[XLEN*k +: XLEN];
                hit1    = 1'b1;
            end
            if (!hit2 && fwd_en_i[k] && fwd_idx_i[5*k +: 5] == rs2_idx_o && rs2_idx_o != 5'd0) begin
                rs2_fwd = fwd_data_i[XLEN*k +: XLEN];
                hit2    = 1'b1;
            end
        end
        if (rs1_idx_o == 5'd0) rs1_fwd = '0;
        if (rs2_idx_o == 5'd0) rs2_fwd = '0;
        if (!rs1_en) rs1_fwd = rs1_rdata_i;
        if (!rs2_en) rs2_fwd = rs2_rdata_i;
    end

    assign hazard   = head_vld & ex_ld_i & (ex_rd_idx_i != 5'd0) &
                      ((rs1_en & (rs1_idx_o == ex_rd_idx_i)) | (rs2_en & (rs2_idx_o == ex_rd_idx_i)));
    assign fire     = head_vld & ~hazard & (~id_valid_o | ex_ready_i) & ~flush_i;
    assign stall_ev = head_vld & hazard & (~id_valid_o | ex_ready_i) & ~flush_i;

    // Buffer storage; contents are qualified by count_q so they need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf_q[wr_ptr_q]    <= if_pc_i;
            instr_buf_q[wr_ptr_q] <= if_instr_i;
        end
    end

    // Buffer pointers and occupancy; flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ID/EX register: load on fire, drop valid once EX takes it, hold while EX stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_o  <= 1'b0;
            id_pc_o     <= '0;
            id_instr_o  <= '0;
            id_rs1_o    <= '0;
            id_rs2_o    <= '0;
            id_imm_o    <= '0;
            id_rd_idx_o <= '0;
            id_rd_en_o  <= 1'b0;
            id_ill_o    <= 1'b0;
        end else if (flush_i) begin
            id_valid_o  <= 1'b0;
        end else if (fire) begin
            id_valid_o  <= 1'b1;
            id_pc_o     <= head_pc;
            id_instr_o  <= head_instr;
            id_rs1_o    <= rs1_fwd;
            id_rs2_o    <= rs2_fwd;
            id_imm_o    <= imm_ext;
            id_rd_idx_o <= head_instr[11:7];
            id_rd_en_o  <= rd_en;
            id_ill_o    <= ill;
        end else if (id_valid_o && ex_ready_i) begin
            id_valid_o  <= 1'b0;
        end
    end

    // Saturating count of cycles lost to load-use hazards; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_ev && stall_cnt_o != 16'hFFFF) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
endmodule
